// File: rtl/sdram_if_pkg.sv
// Shared definitions for the SDRAM client-interface responder.
// Holds the default client widths, the default handshake timing and the
// FSM state encoding used by sdram_bram_responder.
package sdram_if_pkg;

  // Default client interface widths.
  localparam int SDRAM_ADDR_WIDTH = 25;
  localparam int SDRAM_DATA_WIDTH = 8;

  // Default backing store size and handshake timing, in clk cycles.
  localparam int DEF_MEM_ADDR_WIDTH   = 12;
  localparam int DEF_WRITE_CYCLES     = 4;
  localparam int DEF_READ_CYCLES      = 6;
  localparam int DEF_REFRESH_INTERVAL = 780;
  localparam int DEF_REFRESH_CYCLES   = 8;

  // Width of the per-operation and refresh-interval counters.
  localparam int CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_DONE = 3'd3,
    ST_REFRESH   = 3'd4
  } state_t;

endpackage

// File: rtl/sdram_bram_byte_ram.sv
// Single-port synchronous RAM, write-first, one-cycle read latency.
// No reset and no read enable so it maps onto iCE40 block RAM.
// Ports:
//   clk      clock
//   we_i     write strobe
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data, registered; shows wdata_i on a write cycle
module sdram_bram_byte_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/sdram_bram_responder.sv
// Block-RAM backed stand-in for the SDRAM controller client interface.
// Reproduces the controller's ack / busy / rd_ready handshake timing so the
// command path can be exercised without external memory.
// Optional refresh stalls: define SDRAM_BRAM_RESPONDER_REFRESH_EN.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   wr_addr/wr_enable/wr_data   write request (level, held until ack)
//   rd_addr/rd_enable           read request (level, held until ack)
//   rd_data, rd_ready    read result and its one-cycle valid pulse
//   busy, ack            operation in progress, request accepted pulse
module sdram_bram_responder
  import sdram_if_pkg::*;
#(
  parameter int ADDR_WIDTH       = SDRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH       = SDRAM_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH   = DEF_MEM_ADDR_WIDTH,
  parameter int WRITE_CYCLES     = DEF_WRITE_CYCLES,
  parameter int READ_CYCLES      = DEF_READ_CYCLES,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int REFRESH_CYCLES   = DEF_REFRESH_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_enable,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ready,
  output logic                  busy,
  output logic                  ack
);

  if (WRITE_CYCLES < 1 || READ_CYCLES < 2 || REFRESH_INTERVAL < 1 ||
      REFRESH_CYCLES < 1) begin : g_bad_params
    $error("sdram_bram_responder: illegal timing parameters");
  end

  localparam logic [CNT_WIDTH-1:0] WR_LAST  = CNT_WIDTH'(WRITE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(READ_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REF_LAST = CNT_WIDTH'(REFRESH_CYCLES);

  state_t                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      both_q, both_d;   // read queued behind the write
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      ack_q, ack_d, busy_q, busy_d;
  logic                      rd_ready_q, rd_ready_d;
  logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic                      refresh_pending;
  logic                      ram_we;
  logic [MEM_ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  // Upper client address bits are ignored: the RAM aliases across them.
  if (ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_alias
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                                rd_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};
  end

`ifdef SDRAM_BRAM_RESPONDER_REFRESH_EN
  // Free-running interval timer; it keeps counting through stalls so the
  // refresh period does not stretch.
  logic [CNT_WIDTH-1:0] ref_timer_q;
  logic                 ref_pending_q;
  logic                 ref_tick;
  logic                 ref_take;

  assign ref_tick = (ref_timer_q == CNT_WIDTH'(REFRESH_INTERVAL - 1));
  assign ref_take = (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_timer_q   <= '0;
      ref_pending_q <= 1'b0;
    end else begin
      ref_timer_q   <= ref_tick ? '0 : ref_timer_q + 1'b1;
      ref_pending_q <= (ref_pending_q & ~ref_take) | ref_tick;
    end
  end

  assign refresh_pending = ref_pending_q;
`else
  assign refresh_pending = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      both_q     <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_data_q  <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      both_q     <= both_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_data_q  <= wr_data_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      rd_ready_q <= rd_ready_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next state. cnt_q counts the busy cycles already issued in the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    both_d    = both_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (refresh_pending) begin
          state_d = ST_REFRESH;
          cnt_d   = CNT_WIDTH'(1);   // first refresh busy cycle starts now
        end else if (wr_enable || rd_enable) begin
          state_d   = wr_enable ? ST_WRITE : ST_READ;
          both_d    = wr_enable && rd_enable;
          wr_addr_d = wr_addr[MEM_ADDR_WIDTH-1:0];
          rd_addr_d = rd_addr[MEM_ADDR_WIDTH-1:0];
          wr_data_d = wr_data;
        end
      end
      ST_WRITE: begin
        if (cnt_q == WR_LAST) begin
          // A combined request chains straight into the read; this edge
          // already issues the read's first busy cycle.
          state_d = both_q ? ST_READ : ST_IDLE;
          cnt_d   = both_q ? CNT_WIDTH'(1) : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_q >= RD_LAST) state_d = ST_READ_DONE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      ST_READ_DONE: begin
        state_d = ST_IDLE;
        both_d  = 1'b0;
        cnt_d   = '0;
      end
      ST_REFRESH: begin
        if (cnt_q >= REF_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values registered at the coming edge.
  always_comb begin
    ack_d      = 1'b0;
    busy_d     = 1'b0;
    rd_ready_d = 1'b0;
    rd_data_d  = rd_data_q;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = refresh_pending;
        ack_d  = !refresh_pending && (wr_enable || rd_enable);
      end
      ST_WRITE:   busy_d = (cnt_q != WR_LAST) || both_q;
      ST_READ:    busy_d = 1'b1;
      ST_READ_DONE: begin
        rd_ready_d = 1'b1;
        rd_data_d  = ram_rdata;
      end
      ST_REFRESH: busy_d = (cnt_q < REF_LAST);
      default:    busy_d = 1'b0;
    endcase
  end

  // The RAM is written in the ack cycle; every READ cycle re-reads the
  // latched address so ram_rdata is valid during READ_DONE.
  assign ram_we   = (state_q == ST_WRITE) && (cnt_q == '0);
  assign ram_addr = (state_q == ST_WRITE) ? wr_addr_q : rd_addr_q;

  sdram_bram_byte_ram #(
    .ADDR_WIDTH (MEM_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wr_data_q),
    .rdata_o (ram_rdata)
  );

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign rd_ready = rd_ready_q;
  assign rd_data  = rd_data_q;

endmodule
